arm_iter_mul: RTL

Iterative multiply unit for the ARM core, generalising the single-cycle ALU with a multi-cycle, WIDTH-parametrised shift-add multiplier for MUL, MLA, UMULL and SMULL. It sits beside the ALU in the datapath. The controller issues a start pulse and stalls PC/register writeback while `busy` is high, then captures the result and N/Z flags on `done`. The unit has one operation in flight at a time and holds its result until the next accepted start.

---
 rtl/arm_iter_mul.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arm_iter_mul.sv
// Iterative shift-add multiplier for MUL/MLA/UMULL/SMULL, WIDTH-parametrised.
// Optional early termination on zero multiplier: ARM_MUL_EARLY_TERM_EN.
module arm_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               neg;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_add;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   lo_nx;
  logic [WIDTH-1:0]   hi_nx;
  logic               n_nx;
  logic               z_nx;
  logic               last;

  // SMULL runs on magnitudes; the most negative value maps to 2^(W-1).
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (op == OP_SMULL && a[WIDTH-1]) a_mag = -a;
    if (op == OP_SMULL && b[WIDTH-1]) b_mag = -b;
  end

  always_comb begin
    prod_add = prod;
    if (mplier[0]) prod_add = prod + mcand;
  end

  always_comb begin
    prod_fix = prod;
    if (neg) prod_fix = -prod;
    lo_nx = prod_fix[WIDTH-1:0];
    if (op_q == OP_MLA) lo_nx = prod_fix[WIDTH-1:0] + acc_q;
    hi_nx = '0;
    if (op_q[1]) hi_nx = prod_fix[2*WIDTH-1:WIDTH];
    n_nx = op_q[1] ? hi_nx[WIDTH-1] : lo_nx[WIDTH-1];
    z_nx = (lo_nx == '0) && (hi_nx == '0);
  end

`ifdef ARM_MUL_EARLY_TERM_EN
  assign last = (cnt == CW'(1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      neg       <= 1'b0;
      mplier    <= '0;
      acc_q     <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q   <= op;
            neg    <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc_q  <= acc;
            prod   <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (last) state <= FIX;
        end
        FIX: begin
          result_lo <= lo_nx;
          result_hi <= hi_nx;
          flags     <= {n_nx, z_nx};
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
